// File: rtl/divisor_pkg.sv
// Shared constants and state type for the restoring divider.
package divisor_pkg;

    localparam int WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on underflow.
module div_restoring_step #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem, dividend_msb};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // On success the true difference is below the divisor, so the low WIDTH bits hold it exactly.
    assign rem_next = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/divisor_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH+1 edges start-to-done.
//
// state  | meaning
// IDLE   | post-reset, waiting for start
// BUSY   | iterating, one shift/subtract/restore step per clock
// FINISH | Q/R valid and held, done=1, waiting for next start
module divisor_restoring
    import divisor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, rem_nxt;
    logic             q_bit, accept, last_step;

    assign accept    = start && ((state == IDLE) || (state == FINISH));
    assign last_step = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem),
        .dividend_msb (dvd[WIDTH-1]),
        .divisor      (dvs),
        .rem_next     (rem_nxt),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = FINISH;
            FINISH:  if (start)     state_nxt = BUSY;
            default:                state_nxt = IDLE;
        endcase
    end

    // dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            Q    <= '0;
            R    <= '0;
            done <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            dvd  <= A_in;
            dvs  <= B_in;
            rem  <= '0;
            done <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_nxt;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            if (last_step) begin
                Q    <= {dvd[WIDTH-2:0], q_bit};
                R    <= rem_nxt;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divisor_restoring.sv
// Self-checking bench for divisor_restoring: directed table, held-start and reset corners, random vs. arithmetic model.
module tb_divisor_restoring;

    localparam int W   = 7;
    localparam int LAT = W + 1;

    logic         clk, rst, start, done;
    logic [W-1:0] A_in, B_in, Q, R;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] a, b, q, r;
    } vec_t;

    vec_t tbl[7];

    divisor_restoring #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A_in  (A_in),
        .B_in  (B_in),
        .Q     (Q),
        .R     (R),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Plain-arithmetic reference: divide-by-zero yields all-ones quotient, dividend as remainder.
    function automatic void model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one start at the next negedge, then wait (bounded) for done; checks drop, latency, stability.
    task automatic run_div(input int a, input int b, output int q_out, output int r_out);
        int lat;
        int q0, r0;
        bit stable;
        @(negedge clk);
        A_in  = W'(a);
        B_in  = W'(b);
        start = 1'b1;
        q0 = int'(Q);
        r0 = int'(R);
        @(posedge clk); #1;
        check("done_drop", int'(done), 0);
        @(negedge clk);
        start = 1'b0;
        lat    = 1;
        stable = 1'b1;
        while (!done && lat < 4 * LAT) begin
            if (int'(Q) != q0 || int'(R) != r0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("qr_stable_busy", int'(stable), 1);
        check("latency", lat, LAT);
        q_out = int'(Q);
        r_out = int'(R);
    endtask

    initial begin
        int q, r, eq, er, a, b;

        tbl[0] = '{a: 7'd7,   b: 7'd2,  q: 7'd3,   r: 7'd1};
        tbl[1] = '{a: 7'd50,  b: 7'd7,  q: 7'd7,   r: 7'd1};
        tbl[2] = '{a: 7'd99,  b: 7'd5,  q: 7'd19,  r: 7'd4};
        tbl[3] = '{a: 7'd120, b: 7'd10, q: 7'd12,  r: 7'd0};
        tbl[4] = '{a: 7'd127, b: 7'd1,  q: 7'd127, r: 7'd0};
        tbl[5] = '{a: 7'd5,   b: 7'd9,  q: 7'd0,   r: 7'd5};
        tbl[6] = '{a: 7'd45,  b: 7'd0,  q: 7'd127, r: 7'd45};

        rst = 1'b0; start = 1'b0; A_in = '0; B_in = '0;
        #3;
        check("reset_q", int'(Q), 0);
        check("reset_r", int'(R), 0);
        check("reset_done", int'(done), 0);
        #4 rst = 1'b1;

        // Directed table, issued back-to-back from FINISH after the first.
        for (int i = 0; i < 7; i++) begin
            run_div(int'(tbl[i].a), int'(tbl[i].b), q, r);
            check($sformatf("tbl%0d_q", i), q, int'(tbl[i].q));
            check($sformatf("tbl%0d_r", i), r, int'(tbl[i].r));
            check($sformatf("tbl%0d_done", i), int'(done), 1);
        end

        // FINISH holds results across idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("finish_hold_q", int'(Q), 127);
        check("finish_hold_r", int'(R), 45);
        check("finish_hold_done", int'(done), 1);

        // start held high with operands changed mid-BUSY: first result uses original operands,
        // then the still-high start is re-accepted from FINISH with the new operands.
        @(negedge clk);
        A_in = 7'd100; B_in = 7'd3; start = 1'b1;
        @(posedge clk); #1;
        check("held_accept_done", int'(done), 0);
        @(negedge clk);
        A_in = 7'd11; B_in = 7'd4;
        begin
            int lat = 1;
            while (!done && lat < 4 * LAT) begin
                @(posedge clk); #1;
                lat++;
            end
            check("held_latency", lat, LAT);
        end
        check("held_q", int'(Q), 33);
        check("held_r", int'(R), 1);
        @(posedge clk); #1;
        check("held_reaccept_done", int'(done), 0);
        @(negedge clk);
        start = 1'b0;
        begin
            int lat = 1;
            while (!done && lat < 4 * LAT) begin
                @(posedge clk); #1;
                lat++;
            end
            check("reaccept_latency", lat, LAT);
        end
        check("reaccept_q", int'(Q), 2);
        check("reaccept_r", int'(R), 3);

        // Reset at step 3 of a division aborts it with no partial result.
        @(negedge clk);
        A_in = 7'd7; B_in = 7'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_q", int'(Q), 0);
        check("abort_r", int'(R), 0);
        check("abort_done", int'(done), 0);
        #1 rst = 1'b1;
        run_div(7, 2, q, r);
        check("post_reset_q", q, 3);
        check("post_reset_r", r, 1);

        // Random operands against the arithmetic model, including some divide-by-zero.
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
            model(a, b, eq, er);
            run_div(a, b, q, r);
            check($sformatf("rnd%0d_q(%0d/%0d)", i, a, b), q, eq);
            check($sformatf("rnd%0d_r(%0d/%0d)", i, a, b), r, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
